controle_multiciclo: RTL

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

---
 rtl/ula_pkg.sv | 123 ++++++++++++
 rtl/controle_multiciclo_if.sv | 38 +++
 rtl/ula_op_decoder.sv | 31 +++
 rtl/controle_multiciclo.sv | 122 ++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg
// Shared constants for the multicycle datapath: ULA operation codes, control
// FSM state encodings, instruction opcode/funct values, and the bundle of
// per-state control outputs together with its decode function.
// Ports: none (package).
package ula_pkg;

  // ULA operation codes
  localparam logic [3:0] ULA_AND = 4'b0000;
  localparam logic [3:0] ULA_OR  = 4'b0001;
  localparam logic [3:0] ULA_ADD = 4'b0010;
  localparam logic [3:0] ULA_XOR = 4'b0011;
  localparam logic [3:0] ULA_SUB = 4'b0110;
  localparam logic [3:0] ULA_SLT = 4'b0111;
  localparam logic [3:0] ULA_NOR = 4'b1100;

  // Opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct, IR[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Control FSM states; codes 12-15 are unused and fall back to FETCH
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] ula_op;
  } ctrl_t;

  // Pure state-dependent control values. Signals that also depend on inputs
  // (branch pc_en, R-type ula_op, illegal) are overlaid by the controller.
  function automatic ctrl_t state_ctrl(state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ula_op    = ULA_ADD;
        c.pc_en     = 1'b1;
      end
      ST_DECODE: begin
        c.alu_src_b = 2'b11;
        c.ula_op    = ULA_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.ula_op    = ULA_ADD;
      end
      ST_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      ST_R_EXEC: begin
        c.alu_src_a = 1'b1;
      end
      ST_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      ST_ADDI_WB: begin
        c.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.ula_op    = ULA_SUB;
        c.pc_source = 2'b01;
      end
      ST_JUMP: begin
        c.pc_source = 2'b10;
        c.pc_en     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// controle_multiciclo_if
// Bundles the instruction fields and flag coming from the datapath with the
// control lines going back to it.
// Modports:
//   master - control unit: takes opcode/funct/zero, drives all control lines
//   slave  - datapath side: drives opcode/funct/zero, takes control lines
interface controle_multiciclo_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;

  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic       illegal;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [3:0] ula_op;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero,
    output pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, illegal, alu_src_b, pc_source, ula_op, state
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, illegal, alu_src_b, pc_source, ula_op, state
  );
endinterface

// File: rtl/ula_op_decoder.sv
// ula_op_decoder
// Maps an R-type funct field to the ULA operation and flags whether the
// funct is one of the supported R-type operations.
// Ports:
//   funct  in  6  IR[5:0]
//   ula_op out 4  ULA operation (0000 when funct is not supported)
//   legal  out 1  funct is a supported R-type operation
module ula_op_decoder
  import ula_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] ula_op,
  output logic       legal
);

  always_comb begin
    ula_op = 4'b0000;
    legal  = 1'b1;
    case (funct)
      FN_ADD:  ula_op = ULA_ADD;
      FN_SUB:  ula_op = ULA_SUB;
      FN_AND:  ula_op = ULA_AND;
      FN_OR:   ula_op = ULA_OR;
      FN_XOR:  ula_op = ULA_XOR;
      FN_NOR:  ula_op = ULA_NOR;
      FN_SLT:  ula_op = ULA_SLT;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// controle_multiciclo
// Moore control FSM for the multicycle processor. Per-state control values
// are registered alongside the state; the few input-dependent outputs
// (branch pc_en, R-type ula_op, illegal) and the reset gating are overlaid
// combinationally.
// Ports:
//   clk    in  1  sole clock, rising edge
//   reset  in  1  synchronous, active-high
//   bus    master modport of controle_multiciclo_if (opcode/funct/zero in,
//          control lines and debug state out)
//
// state     | meaning
// ----------+----------------------------------------------
// FETCH     | read instruction, IR <= mem, PC <= PC + 4
// DECODE    | classify opcode, ALUOut <= branch target
// MEM_ADDR  | compute lw/sw effective address
// MEM_READ  | read data memory
// MEM_WB    | write loaded word to register file
// MEM_WRITE | write data memory
// R_EXEC    | execute R-type op selected by funct
// R_WB      | write R-type result to rd
// BRANCH    | compare operands, take branch if zero
// JUMP      | load jump target into PC
// ADDI_EXEC | add sign-extended immediate
// ADDI_WB   | write addi result to rt
module controle_multiciclo
  import ula_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  controle_multiciclo_if.master  bus
);

  state_t     state_q;
  state_t     state_d;
  ctrl_t      ctrl_q;
  logic       is_store_q;
  logic [3:0] r_ula_op;
  logic       funct_legal;
  logic       instr_legal;

  ula_op_decoder u_ula_op_decoder (
    .funct  (bus.funct),
    .ula_op (r_ula_op),
    .legal  (funct_legal)
  );

  always_comb begin
    instr_legal = 1'b0;
    case (bus.opcode)
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: instr_legal = 1'b1;
      OP_RTYPE:                            instr_legal = funct_legal;
      default:                             instr_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_RTYPE:     state_d = funct_legal ? ST_R_EXEC : ST_FETCH;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EXEC;
          default:      state_d = ST_FETCH;
        endcase
      end
      // lw/sw choice was latched in DECODE so the opcode is not re-read here
      ST_MEM_ADDR:  state_d = is_store_q ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  state_d = ST_MEM_WB;
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_ADDI_EXEC: state_d = ST_ADDI_WB;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      ctrl_q     <= state_ctrl(ST_FETCH);
      is_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
      if (state_q == ST_DECODE) begin
        is_store_q <= (bus.opcode == OP_SW);
      end
    end
  end

  always_comb begin
    bus.iord       = ctrl_q.iord;
    bus.mem_read   = ctrl_q.mem_read;
    bus.mem_write  = ctrl_q.mem_write;
    bus.ir_write   = ctrl_q.ir_write;
    bus.mem_to_reg = ctrl_q.mem_to_reg;
    bus.reg_dst    = ctrl_q.reg_dst;
    bus.reg_write  = ctrl_q.reg_write;
    bus.alu_src_a  = ctrl_q.alu_src_a;
    bus.alu_src_b  = ctrl_q.alu_src_b;
    bus.pc_source  = ctrl_q.pc_source;
    bus.state      = state_q;
    // beq writes the PC in the same cycle the ULA reports equality
    bus.pc_en      = (state_q == ST_BRANCH) ? bus.zero : ctrl_q.pc_en;
    bus.ula_op     = (state_q == ST_R_EXEC) ? r_ula_op : ctrl_q.ula_op;
    bus.illegal    = (state_q == ST_DECODE) && !instr_legal;
    // Side-effecting strobes are suppressed while reset is held, so a reset
    // landing mid-instruction cannot corrupt memory or registers.
    if (reset) begin
      bus.pc_en     = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.ir_write  = 1'b0;
      bus.reg_write = 1'b0;
      bus.illegal   = 1'b0;
    end
  end

endmodule
